nasti_lite_read_buf: RTL and testbench
======================================

# nasti_lite_read_buf

Read-direction counterpart of the NASTI-lite write buffer. It accepts one NASTI (AXI4) read burst at a time on a full AR channel and splits every beat into single-word NASTI-lite AR requests. It gathers the lite R responses back into full-width NASTI R beats and returns them with a merged response code. It sits between a NASTI master/crossbar port and a NASTI-lite peripheral bus.

## Interface
- BUF_DEPTH, 2, max lite reads outstanding; must be >= NASTI_DATA_WIDTH/LITE_DATA_WIDTH
- ID_WIDTH, 1, id width
- ADDR_WIDTH, 8, address width
- NASTI_DATA_WIDTH, 64, NASTI data width; integer multiple of LITE_DATA_WIDTH
- LITE_DATA_WIDTH, 32, lite data width; only 32 or 64 (elaboration $fatal otherwise)
- USER_WIDTH, 1, user field width (>0)

One clock; reset is asynchronous and active-low.

- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- nasti_ar_id/addr/len/size/burst/lock/cache/prot/qos/region/user  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/4/4/USER_WIDTH  NASTI read address
- nasti_ar_valid  in  1; nasti_ar_ready  out  1
- nasti_r_id  out  ID_WIDTH; nasti_r_data  out  NASTI_DATA_WIDTH; nasti_r_resp  out  2; nasti_r_last  out  1; nasti_r_user  out  USER_WIDTH
- nasti_r_valid  out  1; nasti_r_ready  in  1
- lite_ar_id/addr/prot/qos/region/user  out  ID_WIDTH/ADDR_WIDTH/3/4/4/USER_WIDTH  lite read address
- lite_ar_valid  out  1; lite_ar_ready  in  1
- lite_r_id/data/resp/user  in  ID_WIDTH/LITE_DATA_WIDTH/2/USER_WIDTH  lite read data; lite_r_id is ignored
- lite_r_valid  in  1; lite_r_ready  out  1

## Operation
- States: IDLE and BURST. IDLE: nasti_ar_ready=1. An AR handshake latches id, addr, len, size, prot, qos, region and user, then moves to BURST. BURST: nasti_ar_ready=0.
- Only INCR bursts are supported; burst, lock and cache are ignored.
- Let LB = LITE_DATA_WIDTH/8, NB = NASTI_DATA_WIDTH/8, and K = max(1, (1<<size)/LB) lite reads per beat.
- size > log2(NB) is illegal and its behaviour is undefined.
- Total lite reads = (len+1)*K, counted by a 9+log2(K)-bit issue counter.
- Issue address: starts at the latched addr and increments by max(LB, 1<<size) per lite read. It is not re-aligned.
- Lite sideband outputs come from the latched fields. lite_ar_id = latched id.
- lite_ar_valid = BURST && issue count remaining && outstanding < BUF_DEPTH.
- Outstanding counter: +1 on a lite AR handshake, -1 on a lite R handshake. Both in one cycle leaves it unchanged.
- Gather: the lite R data word is written into the beat register at lane addr[log2(NB)-1:log2(LB)] of its request address. A FIFO of depth BUF_DEPTH holds these lane indices. Other lanes hold their previous contents.
- Collect counter counts 0..K. lite_r_ready = BURST && collect < K.
- When collect reaches K, nasti_r_valid=1. The outputs are then stable:
  - nasti_r_data = beat register.
  - nasti_r_resp = numeric max of the K lite resp codes for that beat.
  - nasti_r_user = user of the last lite word received.
  - nasti_r_id = latched id.
- nasti_r_last = 1 on beat number len.
- On a NASTI R handshake, collect and resp are cleared. If that beat was the last, the block returns to IDLE.

## Timing
- Reset values:
  - nasti_ar_ready=1, nasti_r_valid=0, nasti_r_last=0, nasti_r_resp=0, nasti_r_data=0.
  - lite_ar_valid=0, lite_r_ready=0, all counters 0, state IDLE.
- AR handshake at edge N: lite_ar_valid=1 from cycle N+1.
- One lite AR is issued per cycle while ready and credits are available.
- K-th lite R handshake at edge M: nasti_r_valid=1 from cycle M+1.
- No combinational path from nasti_r_ready to lite_r_ready.
  - After the R handshake at edge P, lite_r_ready=1 from cycle P+1.
  - Peak throughput is therefore K lite words per K+1 cycles.
- Once asserted, nasti_r_valid and lite_ar_valid hold until their handshakes. Their payloads are stable while they are held.
- Credit full (outstanding=BUF_DEPTH): lite_ar_valid=0 the same cycle. It re-asserts in the cycle after a lite R handshake frees a credit.
- Last beat handshake at edge Q: nasti_ar_ready=1 in cycle Q+1. A new AR may be accepted at edge Q+1.
- Reset mid-burst clears all state asynchronously. Pending lite responses after reset are the system's responsibility.

## Test plan
- AR addr=0x10 len=0 size=3; lite reads return 0xAAAAAAAA then 0xBBBBBBBB with resp 0 -> lite_ar_addr 0x10 then 0x14; nasti_r_data=0xBBBBBBBB_AAAAAAAA, last=1, resp=0.
- AR addr=0x00 len=3 size=3 with lite_ar_ready=1 and lite_r_valid held 0 -> exactly 2 lite ARs (0x00, 0x04), then lite_ar_valid=0. After responses resume: 8 reads (0x00..0x1C) and 4 R beats, last only on the 4th.
- AR addr=0x04 len=1 size=2 -> lite reads 0x04 and 0x08. Beat 0 carries its word in bits [63:32]; beat 1 carries its word in bits [31:0].
- len=0 size=3, second lite resp=2 (SLVERR), first resp=0 -> nasti_r_resp=2.
- len=1 size=3 with nasti_r_ready low for 5 cycles after beat 0 is valid -> lite_r_ready=0 throughout, beat 0 data stable, no response lost.
- rstn pulsed low for 1 cycle after 3 of 8 lite reads in the len=3 burst -> all valids 0, nasti_ar_ready=1; the next AR starts a fresh burst at its own address.

Source files
------------

// File: rtl/nasti_lite_read_buf.sv
// NASTI read burst to single-word NASTI-lite reads, regathered into full-width R beats.
// Lite AR one cycle after AR accept; R beat one cycle after its last lite word; lite AR throttled by BUF_DEPTH credits.
module nasti_lite_read_buf_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign pop_dat = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module nasti_lite_read_buf #(
  parameter int BUF_DEPTH        = 2,
  parameter int ID_WIDTH         = 1,
  parameter int ADDR_WIDTH       = 8,
  parameter int NASTI_DATA_WIDTH = 64,
  parameter int LITE_DATA_WIDTH  = 32,
  parameter int USER_WIDTH       = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [ID_WIDTH-1:0]         nasti_ar_id,
  input  logic [ADDR_WIDTH-1:0]       nasti_ar_addr,
  input  logic [7:0]                  nasti_ar_len,
  input  logic [2:0]                  nasti_ar_size,
  input  logic [1:0]                  nasti_ar_burst,
  input  logic                        nasti_ar_lock,
  input  logic [3:0]                  nasti_ar_cache,
  input  logic [2:0]                  nasti_ar_prot,
  input  logic [3:0]                  nasti_ar_qos,
  input  logic [3:0]                  nasti_ar_region,
  input  logic [USER_WIDTH-1:0]       nasti_ar_user,
  input  logic                        nasti_ar_valid,
  output logic                        nasti_ar_ready,
  output logic [ID_WIDTH-1:0]         nasti_r_id,
  output logic [NASTI_DATA_WIDTH-1:0] nasti_r_data,
  output logic [1:0]                  nasti_r_resp,
  output logic                        nasti_r_last,
  output logic [USER_WIDTH-1:0]       nasti_r_user,
  output logic                        nasti_r_valid,
  input  logic                        nasti_r_ready,
  output logic [ID_WIDTH-1:0]         lite_ar_id,
  output logic [ADDR_WIDTH-1:0]       lite_ar_addr,
  output logic [2:0]                  lite_ar_prot,
  output logic [3:0]                  lite_ar_qos,
  output logic [3:0]                  lite_ar_region,
  output logic [USER_WIDTH-1:0]       lite_ar_user,
  output logic                        lite_ar_valid,
  input  logic                        lite_ar_ready,
  input  logic [ID_WIDTH-1:0]         lite_r_id,
  input  logic [LITE_DATA_WIDTH-1:0]  lite_r_data,
  input  logic [1:0]                  lite_r_resp,
  input  logic [USER_WIDTH-1:0]       lite_r_user,
  input  logic                        lite_r_valid,
  output logic                        lite_r_ready
);
  localparam int LB     = LITE_DATA_WIDTH / 8;
  localparam int LB_LOG = $clog2(LB);
  localparam int LANES  = NASTI_DATA_WIDTH / LITE_DATA_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int KW     = $clog2(LANES + 1);
  localparam int ICW    = 9 + $clog2(LANES);
  localparam int OW     = $clog2(BUF_DEPTH + 1);

  if (LITE_DATA_WIDTH != 32 && LITE_DATA_WIDTH != 64) begin : g_bad_lite_width
    $fatal(1, "LITE_DATA_WIDTH must be 32 or 64");
  end
  if (NASTI_DATA_WIDTH % LITE_DATA_WIDTH != 0 || BUF_DEPTH < LANES) begin : g_bad_ratio
    $fatal(1, "NASTI_DATA_WIDTH must be a multiple of LITE_DATA_WIDTH and BUF_DEPTH >= lanes");
  end

  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;

  logic [ID_WIDTH-1:0]         id_q;
  logic [7:0]                  len_q, beat_cnt_q;
  logic [2:0]                  size_q, prot_q;
  logic [3:0]                  qos_q, region_q;
  logic [USER_WIDTH-1:0]       ar_user_q, r_user_q;
  logic [ADDR_WIDTH-1:0]       issue_addr_q, step;
  logic [ICW-1:0]              issue_cnt_q, total_reads;
  logic [OW-1:0]               outst_q;
  logic [KW-1:0]               collect_q, k;
  logic [2:0]                  k_log;
  logic [NASTI_DATA_WIDTH-1:0] beat_q;
  logic [1:0]                  resp_q;
  logic [LANE_W-1:0]           issue_lane, head_lane;
  logic                        ar_hs, lar_hs, lr_hs, r_hs;
  logic                        fifo_empty, fifo_full, unused_ok;

  assign k_log       = (size_q > 3'(LB_LOG)) ? size_q - 3'(LB_LOG) : 3'd0;
  assign k           = KW'(1) << k_log;
  assign total_reads = (ICW'(len_q) + ICW'(1)) << k_log;
  // A beat wider than a lite word advances one lite word per read; narrower beats advance by their own size.
  assign step        = (size_q >= 3'(LB_LOG)) ? ADDR_WIDTH'(LB) : (ADDR_WIDTH'(1) << size_q);
  assign issue_lane  = (LANES > 1) ? LANE_W'(issue_addr_q >> LB_LOG) : '0;

  assign ar_hs  = nasti_ar_valid && nasti_ar_ready;
  assign lar_hs = lite_ar_valid && lite_ar_ready;
  assign lr_hs  = lite_r_valid && lite_r_ready;
  assign r_hs   = nasti_r_valid && nasti_r_ready;

  always_comb begin
    state_d        = state_q;
    nasti_ar_ready = 1'b0;
    lite_ar_valid  = 1'b0;
    lite_r_ready   = 1'b0;
    nasti_r_valid  = 1'b0;
    nasti_r_last   = 1'b0;
    case (state_q)
      IDLE: begin
        nasti_ar_ready = 1'b1;
        if (nasti_ar_valid) state_d = BURST;
      end
      BURST: begin
        lite_ar_valid = (issue_cnt_q != total_reads) && (outst_q < OW'(BUF_DEPTH));
        lite_r_ready  = (collect_q < k);
        nasti_r_valid = (collect_q == k);
        nasti_r_last  = (beat_cnt_q == len_q);
        if (nasti_r_valid && nasti_r_ready && nasti_r_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_q         <= '0;
      len_q        <= '0;
      size_q       <= '0;
      prot_q       <= '0;
      qos_q        <= '0;
      region_q     <= '0;
      ar_user_q    <= '0;
      issue_addr_q <= '0;
      issue_cnt_q  <= '0;
      outst_q      <= '0;
      collect_q    <= '0;
      beat_cnt_q   <= '0;
      beat_q       <= '0;
      resp_q       <= '0;
      r_user_q     <= '0;
    end else begin
      if (ar_hs) begin
        id_q         <= nasti_ar_id;
        len_q        <= nasti_ar_len;
        size_q       <= nasti_ar_size;
        prot_q       <= nasti_ar_prot;
        qos_q        <= nasti_ar_qos;
        region_q     <= nasti_ar_region;
        ar_user_q    <= nasti_ar_user;
        issue_addr_q <= nasti_ar_addr;
        issue_cnt_q  <= '0;
        collect_q    <= '0;
        beat_cnt_q   <= '0;
        resp_q       <= '0;
      end
      if (lar_hs) begin
        issue_addr_q <= issue_addr_q + step;
        issue_cnt_q  <= issue_cnt_q + ICW'(1);
      end
      case ({lar_hs, lr_hs})
        2'b10:   outst_q <= outst_q + OW'(1);
        2'b01:   outst_q <= outst_q - OW'(1);
        default: ;
      endcase
      if (lr_hs) begin
        beat_q[head_lane * LITE_DATA_WIDTH +: LITE_DATA_WIDTH] <= lite_r_data;
        resp_q    <= (lite_r_resp > resp_q) ? lite_r_resp : resp_q;
        r_user_q  <= lite_r_user;
        collect_q <= collect_q + KW'(1);
      end
      if (r_hs) begin
        collect_q  <= '0;
        resp_q     <= '0;
        beat_cnt_q <= beat_cnt_q + 8'd1;
      end
    end
  end

  // Lane of each outstanding lite read, consumed in response order.
  nasti_lite_read_buf_fifo #(.WIDTH(LANE_W), .DEPTH(BUF_DEPTH)) u_lane_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (lar_hs),
    .push_dat (issue_lane),
    .pop      (lr_hs),
    .pop_dat  (head_lane),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign lite_ar_id     = id_q;
  assign lite_ar_addr   = issue_addr_q;
  assign lite_ar_prot   = prot_q;
  assign lite_ar_qos    = qos_q;
  assign lite_ar_region = region_q;
  assign lite_ar_user   = ar_user_q;

  assign nasti_r_id   = id_q;
  assign nasti_r_data = beat_q;
  assign nasti_r_resp = resp_q;
  assign nasti_r_user = r_user_q;

  assign unused_ok = ^{nasti_ar_burst, nasti_ar_lock, nasti_ar_cache, lite_r_id, fifo_empty, fifo_full};
endmodule

// File: tb/tb_nasti_lite_read_buf.sv
// Scoreboarded bench for nasti_lite_read_buf: directed bursts, lite slave model, negedge monitor.
module tb_nasti_lite_read_buf;
  logic        clk = 1'b0;
  logic        rstn;
  logic [0:0]  nasti_ar_id;
  logic [7:0]  nasti_ar_addr, nasti_ar_len;
  logic [2:0]  nasti_ar_size, nasti_ar_prot;
  logic [1:0]  nasti_ar_burst;
  logic        nasti_ar_lock;
  logic [3:0]  nasti_ar_cache, nasti_ar_qos, nasti_ar_region;
  logic [0:0]  nasti_ar_user;
  logic        nasti_ar_valid, nasti_ar_ready;
  logic [0:0]  nasti_r_id, nasti_r_user;
  logic [63:0] nasti_r_data;
  logic [1:0]  nasti_r_resp;
  logic        nasti_r_last, nasti_r_valid, nasti_r_ready;
  logic [0:0]  lite_ar_id, lite_ar_user;
  logic [7:0]  lite_ar_addr;
  logic [2:0]  lite_ar_prot;
  logic [3:0]  lite_ar_qos, lite_ar_region;
  logic        lite_ar_valid, lite_ar_ready;
  logic [0:0]  lite_r_id, lite_r_user;
  logic [31:0] lite_r_data;
  logic [1:0]  lite_r_resp;
  logic        lite_r_valid, lite_r_ready;

  always #5 clk = ~clk;

  nasti_lite_read_buf dut (
    .clk(clk), .rstn(rstn),
    .nasti_ar_id(nasti_ar_id), .nasti_ar_addr(nasti_ar_addr), .nasti_ar_len(nasti_ar_len),
    .nasti_ar_size(nasti_ar_size), .nasti_ar_burst(nasti_ar_burst), .nasti_ar_lock(nasti_ar_lock),
    .nasti_ar_cache(nasti_ar_cache), .nasti_ar_prot(nasti_ar_prot), .nasti_ar_qos(nasti_ar_qos),
    .nasti_ar_region(nasti_ar_region), .nasti_ar_user(nasti_ar_user),
    .nasti_ar_valid(nasti_ar_valid), .nasti_ar_ready(nasti_ar_ready),
    .nasti_r_id(nasti_r_id), .nasti_r_data(nasti_r_data), .nasti_r_resp(nasti_r_resp),
    .nasti_r_last(nasti_r_last), .nasti_r_user(nasti_r_user),
    .nasti_r_valid(nasti_r_valid), .nasti_r_ready(nasti_r_ready),
    .lite_ar_id(lite_ar_id), .lite_ar_addr(lite_ar_addr), .lite_ar_prot(lite_ar_prot),
    .lite_ar_qos(lite_ar_qos), .lite_ar_region(lite_ar_region), .lite_ar_user(lite_ar_user),
    .lite_ar_valid(lite_ar_valid), .lite_ar_ready(lite_ar_ready),
    .lite_r_id(lite_r_id), .lite_r_data(lite_r_data), .lite_r_resp(lite_r_resp),
    .lite_r_user(lite_r_user), .lite_r_valid(lite_r_valid), .lite_r_ready(lite_r_ready)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
    logic        id;
  } beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        user;
  } lite_rsp_t;

  logic [8:0] exp_ar[$];
  lite_rsp_t  rsp_q[$];
  beat_t      exp_r[$];

  int n_cmp = 0;
  int n_fail = 0;
  int lar_cnt = 0;
  int beat_cnt = 0;
  int pending = 0;
  bit rsp_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_lite(input logic id, input logic [7:0] addr, input logic [31:0] data,
                           input logic [1:0] resp, input logic user);
    exp_ar.push_back({id, addr});
    rsp_q.push_back('{data: data, resp: resp, user: user});
  endtask

  task automatic push_beat(input logic [63:0] data, input logic [1:0] resp, input logic last,
                           input logic user, input logic id);
    exp_r.push_back('{data: data, resp: resp, last: last, user: user, id: id});
  endtask

  task automatic send_ar(input logic id, input logic [7:0] addr, input logic [7:0] len,
                         input logic [2:0] size);
    int t = 0;
    @(posedge clk); #1;
    nasti_ar_id = id; nasti_ar_addr = addr; nasti_ar_len = len; nasti_ar_size = size;
    nasti_ar_valid = 1'b1;
    do begin @(negedge clk); t++; end while (!nasti_ar_ready && t < 50);
    check("ar_accepted", 64'(nasti_ar_ready), 64'd1);
    @(posedge clk); #1;
    nasti_ar_valid = 1'b0;
  endtask

  task automatic wait_beats(input int target, input string name);
    int t = 0;
    while (beat_cnt < target && t < 300) begin @(posedge clk); #2; t++; end
    check(name, 64'(beat_cnt >= target), 64'd1);
  endtask

  // Lite slave: offers the next queued response once a request is outstanding.
  initial begin
    lite_r_valid = 1'b0; lite_r_data = '0; lite_r_resp = '0; lite_r_user = '0; lite_r_id = '0;
    forever begin
      @(posedge clk); #1;
      if (rsp_en && pending > 0 && rsp_q.size() > 0) begin
        lite_r_valid = 1'b1;
        lite_r_data  = rsp_q[0].data;
        lite_r_resp  = rsp_q[0].resp;
        lite_r_user  = rsp_q[0].user;
      end else begin
        lite_r_valid = 1'b0;
      end
    end
  end

  // Monitor: handshakes are sampled at negedge and complete at the following posedge.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        pending = 0;
        exp_ar.delete();
        rsp_q.delete();
        exp_r.delete();
      end else begin
        if (lite_ar_valid && lite_ar_ready) begin
          lar_cnt++;
          pending++;
          if (exp_ar.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL lite_ar_unexpected: got addr %h, expected none", lite_ar_addr);
          end else check("lite_ar_id_addr", 64'({lite_ar_id, lite_ar_addr}), 64'(exp_ar.pop_front()));
        end
        if (lite_r_valid && lite_r_ready && rsp_q.size() > 0) begin
          void'(rsp_q.pop_front());
          pending--;
        end
        if (nasti_r_valid && nasti_r_ready) begin
          beat_cnt++;
          if (exp_r.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL nasti_r_unexpected: got data %h, expected none", nasti_r_data);
          end else begin
            b = exp_r.pop_front();
            check("r_data", nasti_r_data, b.data);
            check("r_resp", 64'(nasti_r_resp), 64'(b.resp));
            check("r_last", 64'(nasti_r_last), 64'(b.last));
            check("r_user", 64'(nasti_r_user), 64'(b.user));
            check("r_id", 64'(nasti_r_id), 64'(b.id));
          end
        end
      end
    end
  end

  initial begin
    int base;
    int t;
    rstn = 1'b0;
    nasti_ar_id = '0; nasti_ar_addr = '0; nasti_ar_len = '0; nasti_ar_size = '0;
    nasti_ar_burst = 2'd1; nasti_ar_lock = 1'b0; nasti_ar_cache = '0; nasti_ar_prot = 3'd2;
    nasti_ar_qos = '0; nasti_ar_region = '0; nasti_ar_user = '0; nasti_ar_valid = 1'b0;
    nasti_r_ready = 1'b1; lite_ar_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_ar_ready", 64'(nasti_ar_ready), 64'd1);
    check("rst_r_valid", 64'(nasti_r_valid), 64'd0);
    check("rst_r_last", 64'(nasti_r_last), 64'd0);
    check("rst_r_resp", 64'(nasti_r_resp), 64'd0);
    check("rst_r_data", nasti_r_data, 64'd0);
    check("rst_lite_ar_valid", 64'(lite_ar_valid), 64'd0);
    check("rst_lite_r_ready", 64'(lite_r_ready), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Basic two-word gather.
    push_lite(1'b0, 8'h10, 32'hAAAAAAAA, 2'd0, 1'b0);
    push_lite(1'b0, 8'h14, 32'hBBBBBBBB, 2'd0, 1'b1);
    push_beat(64'hBBBBBBBB_AAAAAAAA, 2'd0, 1'b1, 1'b1, 1'b0);
    base = beat_cnt;
    send_ar(1'b0, 8'h10, 8'd0, 3'd2 + 3'd1);
    wait_beats(base + 1, "t1_beats");
    check("t1_ar_ready_after_last", 64'(nasti_ar_ready), 64'd1);

    // Narrow beats: each lands in its own lane, other lane keeps old contents.
    push_lite(1'b1, 8'h04, 32'hC3C3C3C3, 2'd0, 1'b1);
    push_lite(1'b1, 8'h08, 32'h5A5A5A5A, 2'd1, 1'b0);
    push_beat(64'hC3C3C3C3_AAAAAAAA, 2'd0, 1'b0, 1'b1, 1'b1);
    push_beat(64'hC3C3C3C3_5A5A5A5A, 2'd1, 1'b1, 1'b0, 1'b1);
    base = beat_cnt;
    send_ar(1'b1, 8'h04, 8'd1, 3'd2);
    wait_beats(base + 2, "t3_beats");

    // Credit limit with responses held, then a full 4-beat burst.
    rsp_en = 1'b0;
    for (int i = 0; i < 8; i++) push_lite(1'b0, 8'(4 * i), 32'hD000_0000 + 32'(i), 2'd0, 1'b0);
    for (int b = 0; b < 4; b++)
      push_beat({32'hD000_0000 + 32'(2 * b + 1), 32'hD000_0000 + 32'(2 * b)}, 2'd0, (b == 3), 1'b0, 1'b0);
    base = lar_cnt;
    t = beat_cnt;
    send_ar(1'b0, 8'h00, 8'd3, 3'd3);
    repeat (6) @(posedge clk);
    #2;
    check("t2_credit_lite_ars", 64'(lar_cnt - base), 64'd2);
    check("t2_credit_ar_valid", 64'(lite_ar_valid), 64'd0);
    rsp_en = 1'b1;
    wait_beats(t + 4, "t2_beats");
    check("t2_total_lite_ars", 64'(lar_cnt - base), 64'd8);

    // Response merge: SLVERR dominates OKAY.
    push_lite(1'b0, 8'h30, 32'h01234567, 2'd0, 1'b0);
    push_lite(1'b0, 8'h34, 32'h89ABCDEF, 2'd2, 1'b0);
    push_beat(64'h89ABCDEF_01234567, 2'd2, 1'b1, 1'b0, 1'b0);
    base = beat_cnt;
    send_ar(1'b0, 8'h30, 8'd0, 3'd3);
    wait_beats(base + 1, "t4_beats");

    // Master stall on beat 0.
    nasti_r_ready = 1'b0;
    push_lite(1'b1, 8'h20, 32'h11111111, 2'd0, 1'b0);
    push_lite(1'b1, 8'h24, 32'h22222222, 2'd0, 1'b0);
    push_lite(1'b1, 8'h28, 32'h33333333, 2'd0, 1'b0);
    push_lite(1'b1, 8'h2C, 32'h44444444, 2'd0, 1'b0);
    push_beat(64'h22222222_11111111, 2'd0, 1'b0, 1'b0, 1'b1);
    push_beat(64'h44444444_33333333, 2'd0, 1'b1, 1'b0, 1'b1);
    base = beat_cnt;
    send_ar(1'b1, 8'h20, 8'd1, 3'd3);
    t = 0;
    while (!nasti_r_valid && t < 50) begin @(posedge clk); #2; t++; end
    check("t5_beat0_valid", 64'(nasti_r_valid), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #2;
      check("t5_stall_lite_r_ready", 64'(lite_r_ready), 64'd0);
      check("t5_stall_data", nasti_r_data, 64'h22222222_11111111);
    end
    nasti_r_ready = 1'b1;
    wait_beats(base + 2, "t5_beats");

    // Reset mid-burst after three lite reads.
    nasti_r_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_lite(1'b0, 8'(4 * i), 32'hE000_0000 + 32'(i), 2'd0, 1'b0);
    base = lar_cnt;
    send_ar(1'b0, 8'h00, 8'd3, 3'd3);
    t = 0;
    while (lar_cnt - base < 3 && t < 50) begin @(posedge clk); #2; t++; end
    check("t6_three_lite_ars", 64'(lar_cnt - base), 64'd3);
    rstn = 1'b0;
    #1;
    check("t6_rst_ar_ready", 64'(nasti_ar_ready), 64'd1);
    check("t6_rst_r_valid", 64'(nasti_r_valid), 64'd0);
    check("t6_rst_lite_ar_valid", 64'(lite_ar_valid), 64'd0);
    check("t6_rst_lite_r_ready", 64'(lite_r_ready), 64'd0);
    @(posedge clk); #2;
    rstn = 1'b1;
    nasti_r_ready = 1'b1;
    push_lite(1'b1, 8'h40, 32'h87654321, 2'd0, 1'b1);
    push_lite(1'b1, 8'h44, 32'h0FEDCBA9, 2'd0, 1'b0);
    push_beat(64'h0FEDCBA9_87654321, 2'd0, 1'b1, 1'b0, 1'b1);
    base = beat_cnt;
    send_ar(1'b1, 8'h40, 8'd0, 3'd3);
    wait_beats(base + 1, "t6_fresh_beats");

    repeat (5) @(posedge clk);
    #2;
    check("exp_r_drained", 64'(exp_r.size()), 64'd0);
    check("exp_ar_drained", 64'(exp_ar.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
